// File: rtl/risc_pkg.sv
// Shared types and constants for the RISC core's data-memory / write-back path.
package risc_pkg;

    localparam int RF_AW   = 3;
    localparam int RISC_DW = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

    // Power-on contents of word idx: the low nibble of the index repeated twice.
    function automatic logic [RISC_DW-1:0] dmem_reset_word(input logic [3:0] idx);
        return {idx, idx};
    endfunction

endpackage

// File: rtl/risc_dmem_array.sv
// Data store: per-word registers with synchronous write, asynchronous read and reset pattern.
module risc_dmem_array
    import risc_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = RISC_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] words [DEPTH];

    // Addresses at or beyond DEPTH match no word: stores vanish, loads read zero.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            logic [DW-1:0] word_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    word_q <= DW'(dmem_reset_word(4'(gi)));
                end else if (we && (waddr == AW'(gi))) begin
                    word_q <= wdata;
                end
            end

            assign words[gi] = word_q;
        end
    endgenerate

    always_comb begin
        rdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr == AW'(i)) begin
                rdata = words[i];
            end
        end
    end

endmodule

// File: rtl/risc_dmem_wb.sv
// Data-memory responder: accepts one load/store at a time, waits WAIT_CYC cycles, then
// answers for one cycle; loads drive the register file's memory-side write port.
module risc_dmem_wb
    import risc_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int AW       = 4,
    parameter int DW       = RISC_DW,
    parameter int WAIT_CYC = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_req,
    input  logic             mem_we,
    input  logic [AW-1:0]    mem_addr,
    input  logic [DW-1:0]    mem_wdata,
    input  logic [RF_AW-1:0] mem_dst,
    output logic             mem_busy,
    output logic [DW-1:0]    dmdataout,
    output logic             load_op,
    output logic             reg_wr_vld,
    output logic [RF_AW-1:0] dst
);

    dmem_state_t      state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             we_q, we_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [RF_AW-1:0] rdst_q, rdst_d;

    logic [DW-1:0]    dmdataout_q, dmdataout_d;
    logic             load_op_q, load_op_d;
    logic             reg_wr_vld_q, reg_wr_vld_d;
    logic [RF_AW-1:0] dst_q, dst_d;

    logic [AW-1:0]    rd_addr;
    logic [DW-1:0]    rd_data;
    logic             cur_we;
    logic [RF_AW-1:0] cur_dst;

    risc_dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    ((state_q == RESP) && we_q),
        .waddr (addr_q),
        .wdata (wdata_q),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        rdst_d       = rdst_q;
        dmdataout_d  = '0;
        load_op_d    = 1'b0;
        reg_wr_vld_d = 1'b0;
        dst_d        = '0;
        // With zero wait states RESP follows acceptance directly, so the live request
        // fields must feed the response registers instead of the not-yet-written latches.
        rd_addr      = addr_q;
        cur_we       = we_q;
        cur_dst      = rdst_q;

        case (state_q)
            IDLE: begin
                rd_addr = mem_addr;
                cur_we  = mem_we;
                cur_dst = mem_dst;
                if (mem_req) begin
                    addr_d  = mem_addr;
                    we_d    = mem_we;
                    wdata_d = mem_wdata;
                    rdst_d  = mem_dst;
                    if (WAIT_CYC > 0) begin
                        state_d = WAIT;
                        cnt_d   = 3'(WAIT_CYC - 1);
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if ((state_d == RESP) && !cur_we) begin
            dmdataout_d  = rd_data;
            load_op_d    = 1'b1;
            reg_wr_vld_d = 1'b1;
            dst_d        = cur_dst;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            rdst_q       <= '0;
            dmdataout_q  <= '0;
            load_op_q    <= 1'b0;
            reg_wr_vld_q <= 1'b0;
            dst_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            rdst_q       <= rdst_d;
            dmdataout_q  <= dmdataout_d;
            load_op_q    <= load_op_d;
            reg_wr_vld_q <= reg_wr_vld_d;
            dst_q        <= dst_d;
        end
    end

    assign mem_busy   = (state_q != IDLE);
    assign dmdataout  = dmdataout_q;
    assign load_op    = load_op_q;
    assign reg_wr_vld = reg_wr_vld_q;
    assign dst        = dst_q;

endmodule

// File: tb/tb_risc_dmem_wb.sv
// Bench for risc_dmem_wb: four instances (wait 1, wait 3, wait 0, depth 12) checked against a memory model.
module tb_risc_dmem_wb;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       req_v;
    logic             we;
    logic [3:0]       addr;
    logic [7:0]       wdata;
    logic [2:0]       mdst;
    logic [3:0]       busy_v, lop_v, vld_v;
    logic [3:0][7:0]  dout_v;
    logic [3:0][2:0]  dst_v;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dut
            risc_dmem_wb #(
                .DEPTH    (gi == 3 ? 12 : 16),
                .AW       (4),
                .DW       (8),
                .WAIT_CYC (gi == 1 ? 3 : (gi == 2 ? 0 : 1))
            ) u_dut (
                .clk        (clk),
                .rst_n      (rst_n),
                .mem_req    (req_v[gi]),
                .mem_we     (we),
                .mem_addr   (addr),
                .mem_wdata  (wdata),
                .mem_dst    (mdst),
                .mem_busy   (busy_v[gi]),
                .dmdataout  (dout_v[gi]),
                .load_op    (lop_v[gi]),
                .reg_wr_vld (vld_v[gi]),
                .dst        (dst_v[gi])
            );
        end
    endgenerate

    typedef struct packed {
        logic       timeout;
        logic [3:0] busy;
        logic [3:0] nvld;
        logic [3:0] idx;
        logic [7:0] dout;
        logic [2:0] dst;
        logic       lop;
        logic [3:0] stray;
    } obs_t;

    int           n_tests = 0;
    int           n_fail  = 0;
    byte unsigned model [4][16];
    obs_t         obs;

    function automatic int wait_of(input int k);
        return (k == 1) ? 3 : ((k == 2) ? 0 : 1);
    endfunction

    function automatic int depth_of(input int k);
        return (k == 3) ? 12 : 16;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 16; i++)
                model[k][i] = 8'(i * 17);
    endtask

    function automatic logic [7:0] model_load(input int k, input int a);
        return (a < depth_of(k)) ? model[k][a] : 8'h00;
    endfunction

    task automatic model_store(input int k, input int a, input logic [7:0] d);
        if (a < depth_of(k)) model[k][a] = d;
    endtask

    // Response expected from one isolated request, indexed from the first sample after acceptance.
    function automatic obs_t expect_of(input int k, input bit w, input int a, input logic [2:0] ds);
        obs_t e;
        e      = '0;
        e.busy = 4'(wait_of(k) + 1);
        e.idx  = 4'hf;
        if (!w) begin
            e.nvld = 4'd1;
            e.idx  = 4'(wait_of(k));
            e.dout = model_load(k, a);
            e.dst  = ds;
            e.lop  = 1'b1;
        end
        return e;
    endfunction

    // Samples instance k for 8 cycles at negedges; the current negedge is sample 0.
    task automatic observe(input int k);
        obs.busy  = '0;
        obs.nvld  = '0;
        obs.idx   = 4'hf;
        obs.dout  = '0;
        obs.dst   = '0;
        obs.lop   = 1'b0;
        obs.stray = '0;
        for (int i = 0; i < 8; i++) begin
            if (busy_v[k]) obs.busy = obs.busy + 4'd1;
            if (vld_v[k]) begin
                obs.nvld = obs.nvld + 4'd1;
                obs.idx  = 4'(i);
                obs.dout = dout_v[k];
                obs.dst  = dst_v[k];
                obs.lop  = lop_v[k];
            end else if (lop_v[k] || dout_v[k] != 8'h00 || dst_v[k] != 3'd0) begin
                obs.stray = obs.stray + 4'd1;
            end
            if (i < 7) @(negedge clk);
        end
    endtask

    task automatic xact(input int k, input bit w, input int a, input logic [7:0] d, input logic [2:0] ds);
        int guard;
        guard       = 0;
        obs.timeout = 1'b0;
        @(negedge clk);
        while (busy_v[k] && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (busy_v[k]) obs.timeout = 1'b1;
        we       = w;
        addr     = 4'(a);
        wdata    = d;
        mdst     = ds;
        req_v    = '0;
        req_v[k] = 1'b1;
        @(negedge clk);
        req_v = '0;
        observe(k);
    endtask

    task automatic test_reset();
        obs_t e;
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({busy_v, vld_v, lop_v, dout_v, dst_v} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0", {busy_v, vld_v, lop_v, dout_v, dst_v});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            e = expect_of(0, 1'b0, i, 3'(i));
            xact(0, 1'b0, i, 8'h00, 3'(i));
            n_tests++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reset_pattern addr %0d: got %h required %h", i, obs, e);
            end
        end
    endtask

    task automatic test_load();
        obs_t e;
        e = expect_of(0, 1'b0, 5, 3'd3);
        xact(0, 1'b0, 5, 8'h00, 3'd3);
        n_tests++;
        if (obs !== e || obs.dout !== 8'h55 || obs.busy !== 4'd2) begin
            n_fail++;
            $display("FAIL load_addr5: got %h required %h", obs, e);
        end
    endtask

    task automatic test_store_load();
        obs_t e;
        e = expect_of(0, 1'b1, 2, 3'd0);
        xact(0, 1'b1, 2, 8'hA5, 3'd0);
        model_store(0, 2, 8'hA5);
        n_tests++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL store_resp: got %h required %h", obs, e);
        end
        e = expect_of(0, 1'b0, 2, 3'd6);
        xact(0, 1'b0, 2, 8'h00, 3'd6);
        n_tests++;
        if (obs !== e || obs.dout !== 8'hA5) begin
            n_fail++;
            $display("FAIL load_after_store: got %h required %h", obs, e);
        end
    endtask

    task automatic test_busy_reject();
        int         nvld;
        logic [7:0] got;
        nvld = 0;
        got  = 8'h00;
        @(negedge clk);
        we = 1'b0; addr = 4'd1; mdst = 3'd2; req_v = 4'b0001;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            if (vld_v[0]) begin
                nvld++;
                got = dout_v[0];
            end
            if (i == 0) begin
                addr = 4'd9;
                mdst = 3'd5;
            end
            if (i == 1) req_v = '0;
            @(negedge clk);
        end
        n_tests++;
        if (nvld !== 1 || got !== model_load(0, 1)) begin
            n_fail++;
            $display("FAIL busy_reject: got %0d responses data %h required 1 response data %h",
                     nvld, got, model_load(0, 1));
        end
    endtask

    task automatic test_reset_mid_wait();
        obs_t e;
        @(negedge clk);
        we = 1'b1; addr = 4'd7; wdata = 8'h3C; req_v = 4'b0010;
        @(negedge clk);
        req_v = '0;
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if ({busy_v, vld_v, lop_v, dout_v, dst_v} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_wait_outputs: got %h required 0", {busy_v, vld_v, lop_v, dout_v, dst_v});
        end
        @(negedge clk);
        // Request presented together with deassertion must be taken at the very next edge.
        rst_n = 1'b1;
        e = expect_of(1, 1'b0, 7, 3'd1);
        we = 1'b0; addr = 4'd7; mdst = 3'd1; req_v = 4'b0010;
        @(negedge clk);
        req_v = '0;
        obs.timeout = 1'b0;
        observe(1);
        n_tests++;
        if (obs !== e || obs.dout !== 8'h77) begin
            n_fail++;
            $display("FAIL reset_mid_wait_load: got %h required %h", obs, e);
        end
    endtask

    task automatic test_zero_wait();
        obs_t        e;
        logic [12:0] got [4];
        logic [12:0] req [4];
        e = expect_of(2, 1'b0, 15, 3'd7);
        xact(2, 1'b0, 15, 8'h00, 3'd7);
        n_tests++;
        if (obs !== e || obs.dout !== 8'hff || obs.idx !== 4'd0) begin
            n_fail++;
            $display("FAIL zero_wait_load15: got %h required %h", obs, e);
        end
        req[0] = {1'b1, 1'b1, model_load(2, 0), 3'd4};
        req[1] = {1'b0, 1'b0, 8'h00, 3'd0};
        req[2] = {1'b1, 1'b1, model_load(2, 8), 3'd5};
        req[3] = {1'b0, 1'b0, 8'h00, 3'd0};
        @(negedge clk);
        we = 1'b0; addr = 4'd0; mdst = 3'd4; req_v = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            got[i] = {busy_v[2], vld_v[2], dout_v[2], dst_v[2]};
            if (i == 0) begin
                addr = 4'd8;
                mdst = 3'd5;
            end
            if (i == 2) req_v = '0;
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (got[i] !== req[i]) begin
                n_fail++;
                $display("FAIL back_to_back cycle %0d: got %h required %h", i, got[i], req[i]);
            end
        end
    endtask

    task automatic test_out_of_range();
        obs_t e;
        e = expect_of(3, 1'b0, 13, 3'd2);
        xact(3, 1'b0, 13, 8'h00, 3'd2);
        n_tests++;
        if (obs !== e || obs.dout !== 8'h00 || obs.nvld !== 4'd1) begin
            n_fail++;
            $display("FAIL oor_load: got %h required %h", obs, e);
        end
        e = expect_of(3, 1'b1, 14, 3'd0);
        xact(3, 1'b1, 14, 8'h5A, 3'd0);
        model_store(3, 14, 8'h5A);
        n_tests++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL oor_store: got %h required %h", obs, e);
        end
        for (int i = 0; i < 12; i++) begin
            e = expect_of(3, 1'b0, i, 3'(i));
            xact(3, 1'b0, i, 8'h00, 3'(i));
            n_tests++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL oor_contents addr %0d: got %h required %h", i, obs, e);
            end
        end
    endtask

    task automatic test_random();
        obs_t       e;
        int         k, a;
        bit         w;
        logic [7:0] d;
        logic [2:0] ds;
        for (int n = 0; n < 80; n++) begin
            k  = $urandom_range(3, 0);
            w  = 1'($urandom_range(1, 0));
            a  = $urandom_range(15, 0);
            d  = 8'($urandom);
            ds = 3'($urandom);
            e  = expect_of(k, w, a, ds);
            xact(k, w, a, d, ds);
            if (w) model_store(k, a, d);
            n_tests++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL random #%0d inst %0d we %0d addr %0d: got %h required %h",
                         n, k, w, a, obs, e);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_v = '0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        mdst  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
        test_load();
        test_store_load();
        test_busy_reject();
        test_reset_mid_wait();
        test_zero_wait();
        test_out_of_range();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
